dual_queue_wrr_arbiter: RTL
===========================

// Module: dual_queue_wrr_arbiter
// PURPOSE
//  Weighted round-robin drain arbiter for the two-queue (a/b) buffer. Sits downstream of both
//  show-ahead queues: watches their empty flags and head words, issues pop_a/pop_b and merges
//  the words into one registered valid/ready stream tagged with its source. Queue a gets
//  WEIGHT_A consecutive grants, queue b gets WEIGHT_B. Grants pass to the other queue whenever
//  the granted queue is empty (work-conserving).
// PARAMETERS
//  D_WIDTH   6  data word width
//  WEIGHT_A  2  max consecutive pops from queue a per turn (1..2**CNT_W-1)
//  WEIGHT_B  1  max consecutive pops from queue b per turn (1..2**CNT_W-1)
//  CNT_W     4  credit counter width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  empty_a    in   1        queue a empty
//  empty_b    in   1        queue b empty
//  head_a     in   D_WIDTH  queue a head word (show-ahead, valid when !empty_a)
//  head_b     in   D_WIDTH  queue b head word
//  pop_a      out  1        consume queue a head this cycle (combinational)
//  pop_b      out  1        consume queue b head this cycle (combinational)
//  out_data   out  D_WIDTH  merged output word (registered)
//  out_src    out  1        0 = word came from a, 1 = from b
//  out_valid  out  1        out_data/out_src valid
//  out_ready  in   1        downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, out_data=0, out_src=0, grant=GRANT_A, credit=WEIGHT_A.
//    pop_a=pop_b=0 while rst=0. A reset mid-stream drops the word held in the output register.
//  - load_en = !out_valid | out_ready. No pop while load_en=0. Under backpressure, out_* stay stable.
//  - Selection when load_en=1:
//    - If the granted queue is non-empty, pop it.
//    - Else, if the other queue is non-empty, pop the other queue.
//    - Else, no pop.
//    - At most one pop per cycle. pop_a and pop_b are never both 1.
//  - On a pop from queue X: out_data<=head_X, out_src<=X, out_valid<=1 at the next edge.
//    Latency is 1 clk from pop to out_valid.
//  - load_en=1 with no pop: out_valid<=0. Transfer completes, no new word.
//  - FSM states GRANT_A and GRANT_B, plus credit counter:
//    - Pop from the granted queue with credit>1: credit-1, grant unchanged.
//    - Pop from the granted queue with credit==1: grant to the other queue, credit=its WEIGHT.
//    - Pop from the non-granted queue Y (granted queue empty): grant=Y, credit=WEIGHT_Y-1.
//      If that credit is 0, grant goes to the other queue with full WEIGHT instead.
//    - No pop: grant and credit hold.
//  - Throughput: 1 word/clk with out_ready=1 and any queue non-empty. No bubble on a grant switch.
//  - Empty flag rising in the same cycle as a pop is not this block's concern. The queue owns
//    underflow; the arbiter never pops a queue whose empty flag is 1.
// CONFIGURATION
//  DUAL_ARB_STATS_EN defined:
//  - Adds outputs stat_a, stat_b [15:0]: count of pops from a and from b.
//  - Counters saturate at 16'hFFFF and reset to 0 by rst.
//  - Adds input stat_clr (synchronous, clears both counters). stat_clr wins over a same-cycle pop.
//  DUAL_ARB_STATS_EN undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  1 Reset: rst=0 mid-cycle -> out_valid=0, pop_a=pop_b=0 immediately; after release with both
//    queues empty, no pops for 10 clk.
//  2 Weighting: a holds 6 words, b holds 3, out_ready=1, WEIGHT_A=2, WEIGHT_B=1 ->
//    out_src sequence 0,0,1,0,0,1,0,0,1; data order preserved per queue; 9 words in 9 clk.
//  3 Work-conserving: a empty, b holds 4 words -> pop_b on 4 consecutive clk;
//    out_valid rises 1 clk after the first pop_b.
//  4 Backpressure: out_valid=1, out_ready=0 for 5 clk -> no pops, out_data/out_src unchanged;
//    out_ready=1 -> next word appears on the following clk.
//  5 Mid-burst empty: grant=A with credit 2, a empties after 1 pop, b non-empty ->
//    pop_b in the next cycle, no idle cycle.
//  6 Stats (DUAL_ARB_STATS_EN): after test 2, stat_a=6 and stat_b=3; stat_clr pulse -> both 0.

Source files
------------

// File: rtl/dual_queue_wrr_arbiter.sv
// Weighted round-robin drain arbiter for two show-ahead queues, merged into one registered valid/ready stream.
// Optional pop statistics counters are enabled by defining DUAL_ARB_STATS_EN.
module dual_queue_wrr_arbiter #(
    parameter int D_WIDTH  = 6,
    parameter int WEIGHT_A = 2,
    parameter int WEIGHT_B = 1,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empty_a,
    input  logic               empty_b,
    input  logic [D_WIDTH-1:0] head_a,
    input  logic [D_WIDTH-1:0] head_b,
    output logic               pop_a,
    output logic               pop_b,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_src,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef DUAL_ARB_STATS_EN
    input  logic               stat_clr,
    output logic [15:0]        stat_a,
    output logic [15:0]        stat_b,
`endif
    output logic               o_dbg_grant,
    output logic [CNT_W-1:0]   o_dbg_credit
);

    // Handshake: a word transfers on a rising edge where out_valid & out_ready are both 1;
    // the output register reloads only when it is empty or being drained (load_en).
    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;

    localparam logic [CNT_W-1:0] W_A = CNT_W'(WEIGHT_A);
    localparam logic [CNT_W-1:0] W_B = CNT_W'(WEIGHT_B);

    grant_t             r_grant;
    logic [CNT_W-1:0]   r_credit;
    logic [D_WIDTH-1:0] r_out_data;
    logic               r_out_src;
    logic               r_out_valid;

    logic               w_load_en;
    logic               w_grant_ne;
    logic               w_other_ne;
    logic               w_pop;
    logic               w_pick_b;
    grant_t             w_next_grant;
    logic [CNT_W-1:0]   w_next_credit;

    assign w_load_en  = !r_out_valid || out_ready;
    assign w_grant_ne = (r_grant == GRANT_A) ? !empty_a : !empty_b;
    assign w_other_ne = (r_grant == GRANT_A) ? !empty_b : !empty_a;
    assign w_pop      = rst && w_load_en && (w_grant_ne || w_other_ne);
    // Fall back to the other queue only when the granted one is empty.
    assign w_pick_b   = w_grant_ne ? (r_grant == GRANT_B) : (r_grant == GRANT_A);

    assign pop_a = w_pop && !w_pick_b;
    assign pop_b = w_pop && w_pick_b;

    always_comb begin
        w_next_grant  = r_grant;
        w_next_credit = r_credit;
        if (w_pop) begin
            if (w_grant_ne) begin
                if (r_credit > CNT_W'(1)) begin
                    w_next_credit = r_credit - CNT_W'(1);
                end else begin
                    w_next_grant  = (r_grant == GRANT_A) ? GRANT_B : GRANT_A;
                    w_next_credit = (r_grant == GRANT_A) ? W_B : W_A;
                end
            end else begin
                // Borrowed pop counts against the borrower's turn; a weight-1 turn is already spent.
                if (((r_grant == GRANT_A) ? W_B : W_A) > CNT_W'(1)) begin
                    w_next_grant  = (r_grant == GRANT_A) ? GRANT_B : GRANT_A;
                    w_next_credit = ((r_grant == GRANT_A) ? W_B : W_A) - CNT_W'(1);
                end else begin
                    w_next_grant  = r_grant;
                    w_next_credit = (r_grant == GRANT_A) ? W_A : W_B;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant     <= GRANT_A;
            r_credit    <= W_A;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_grant  <= w_next_grant;
            r_credit <= w_next_credit;
            if (w_load_en) begin
                r_out_valid <= w_pop;
                if (w_pop) begin
                    r_out_data <= w_pick_b ? head_b : head_a;
                    r_out_src  <= w_pick_b;
                end
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_src      = r_out_src;
    assign out_valid    = r_out_valid;
    assign o_dbg_grant  = r_grant;
    assign o_dbg_credit = r_credit;

`ifdef DUAL_ARB_STATS_EN
    logic [15:0] r_stat_a;
    logic [15:0] r_stat_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_a <= '0;
            r_stat_b <= '0;
        end else if (stat_clr) begin
            r_stat_a <= '0;
            r_stat_b <= '0;
        end else begin
            if (pop_a && (r_stat_a != 16'hFFFF)) r_stat_a <= r_stat_a + 16'd1;
            if (pop_b && (r_stat_b != 16'hFFFF)) r_stat_b <= r_stat_b + 16'd1;
        end
    end

    assign stat_a = r_stat_a;
    assign stat_b = r_stat_b;
`endif

endmodule
